scr1_axi_sram: RTL

AXI4 slave that terminates the memory AXI bridge's master port on a single-port synchronous SRAM (TCM-style macro, 1-cycle read latency). It sits directly downstream of the bridge and serves one transaction at a time. It accepts single-beat reads and writes of byte, halfword or word size. Bursts and out-of-range addresses are answered with error responses and never touch the SRAM.

---
 rtl/scr1_axi_pkg.sv | 33 +++
 rtl/scr1_axi_sram.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scr1_axi_pkg.sv
// Shared AXI definitions for the SCR1 memory-side blocks: response codes,
// the SRAM slave state encoding and a data-width to AXI-size helper.
package scr1_axi_pkg;

  localparam logic [1:0] SCR1_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] SCR1_AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] SCR1_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] SCR1_AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_ACC     = 3'd1,
    WR_RESP    = 3'd2,
    RD_ACC     = 3'd3,
    RD_WAIT    = 3'd4,
    RD_RESP    = 3'd5,
    ERR_WDRAIN = 3'd6,
    ERR_RBEATS = 3'd7
  } type_scr1_axi_sram_fsm_e;

  // AXI size encoding is log2 of the transfer width in bytes.
  function automatic logic [2:0] scr1_axi_width2size(input int unsigned width);
    case (width)
      8:       return 3'd0;
      16:      return 3'd1;
      32:      return 3'd2;
      64:      return 3'd3;
      128:     return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/scr1_axi_sram.sv
// AXI4 single-beat slave in front of a 1-cycle-latency single-port SRAM.
// One transaction at a time; bursts and out-of-range accesses get error responses.
module scr1_axi_sram
  import scr1_axi_pkg::*;
#(
  parameter int                         SCR1_AXI_IDWIDTH = 4,
  parameter int                         SCR1_ADDR_WIDTH  = 32,
  parameter int                         SCR1_SRAM_AWIDTH = 14,
  parameter logic [SCR1_ADDR_WIDTH-1:0] SCR1_SRAM_BASE   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SCR1_AXI_IDWIDTH-1:0] awid,
  input  logic [SCR1_ADDR_WIDTH-1:0]  awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [31:0]                 wdata,
  input  logic [3:0]                  wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [SCR1_AXI_IDWIDTH-1:0] bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [SCR1_AXI_IDWIDTH-1:0] arid,
  input  logic [SCR1_ADDR_WIDTH-1:0]  araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [SCR1_AXI_IDWIDTH-1:0] rid,
  output logic [31:0]                 rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic                        sram_req,
  output logic                        sram_we,
  output logic [SCR1_SRAM_AWIDTH-1:0] sram_addr,
  output logic [3:0]                  sram_be,
  output logic [31:0]                 sram_wdata,
  input  logic [31:0]                 sram_rdata,
  output type_scr1_axi_sram_fsm_e     dbg_state
);

  localparam int         HI       = SCR1_ADDR_WIDTH - 1;
  localparam int         LO       = SCR1_SRAM_AWIDTH + 2;
  localparam logic [2:0] SIZE_MAX = scr1_axi_width2size(32);

  // Handshake rule: a channel transfers on a cycle where valid and ready are
  // both high at the rising edge; ready never waits on anything but state and valids.

  type_scr1_axi_sram_fsm_e     r_state, w_next;
  logic                        r_last_wr;
  logic [7:0]                  r_beats;
  logic [SCR1_AXI_IDWIDTH-1:0] r_bid, r_rid;
  logic [1:0]                  r_bresp, r_rresp;
  logic [31:0]                 r_rdata;
  logic                        r_rlast, r_rvalid, r_bvalid;
  logic                        r_sram_req, r_sram_we;
  logic [SCR1_SRAM_AWIDTH-1:0] r_sram_addr;
  logic [3:0]                  r_sram_be;
  logic [31:0]                 r_sram_wdata;

  logic       w_wr_req, w_rd_req, w_grant_wr, w_grant_rd;
  logic [1:0] w_aw_resp, w_ar_resp;
  logic       w_unused;

  function automatic logic [1:0] classify(input logic [SCR1_ADDR_WIDTH-1:0] addr,
                                          input logic [7:0] len, input logic [2:0] size);
    if (addr[HI:LO] != SCR1_SRAM_BASE[HI:LO]) return SCR1_AXI_RESP_DECERR;
    else if (len != 8'd0 || size > SIZE_MAX)  return SCR1_AXI_RESP_SLVERR;
    else                                      return SCR1_AXI_RESP_OKAY;
  endfunction

  // AW and W are taken together, so a write only competes once both are valid.
  assign w_wr_req   = awvalid & wvalid;
  assign w_rd_req   = arvalid;
  assign w_grant_rd = (r_state == IDLE) & w_rd_req & (~w_wr_req | r_last_wr);
  assign w_grant_wr = (r_state == IDLE) & w_wr_req & (~w_rd_req | ~r_last_wr);
  assign w_aw_resp  = classify(awaddr, awlen, awsize);
  assign w_ar_resp  = classify(araddr, arlen, arsize);
  assign w_unused   = ^{awburst, arburst, awaddr[1:0], araddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_rd)
          w_next = (w_ar_resp == SCR1_AXI_RESP_OKAY) ? RD_ACC : ERR_RBEATS;
        else if (w_grant_wr)
          w_next = (w_aw_resp == SCR1_AXI_RESP_OKAY) ? WR_ACC :
                   (wlast ? WR_RESP : ERR_WDRAIN);
      end
      WR_ACC:     w_next = WR_RESP;
      WR_RESP:    if (bready) w_next = IDLE;
      RD_ACC:     w_next = RD_WAIT;
      RD_WAIT:    w_next = RD_RESP;
      RD_RESP:    if (rready) w_next = IDLE;
      ERR_WDRAIN: if (wvalid && wlast) w_next = WR_RESP;
      ERR_RBEATS: if (rready && r_beats == 8'd0) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    arready = w_grant_rd;
    awready = w_grant_wr;
    wready  = w_grant_wr | (r_state == ERR_WDRAIN);
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr    <= 1'b1;
      r_beats      <= '0;
      r_bid        <= '0;
      r_rid        <= '0;
      r_bresp      <= '0;
      r_rresp      <= '0;
      r_rdata      <= '0;
      r_rlast      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_sram_req   <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_be    <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_sram_req <= (w_next == WR_ACC) || (w_next == RD_ACC);
      r_sram_we  <= (w_next == WR_ACC);
      r_bvalid   <= (w_next == WR_RESP);
      r_rvalid   <= (w_next == RD_RESP) || (w_next == ERR_RBEATS);
      if (w_grant_wr) begin
        r_last_wr    <= 1'b1;
        r_bid        <= awid;
        r_bresp      <= w_aw_resp;
        r_sram_addr  <= awaddr[SCR1_SRAM_AWIDTH+1:2];
        r_sram_be    <= wstrb;
        r_sram_wdata <= wdata;
      end
      if (w_grant_rd) begin
        r_last_wr   <= 1'b0;
        r_rid       <= arid;
        r_rresp     <= w_ar_resp;
        r_sram_addr <= araddr[SCR1_SRAM_AWIDTH+1:2];
        r_rdata     <= '0;
        r_beats     <= arlen;
        r_rlast     <= (w_ar_resp != SCR1_AXI_RESP_OKAY) && (arlen == 8'd0);
      end
      if (r_state == RD_WAIT) begin
        r_rdata <= sram_rdata;
        r_rlast <= 1'b1;
      end
      if (r_state == RD_RESP && rready) r_rlast <= 1'b0;
      if (r_state == ERR_RBEATS && rready) begin
        if (r_beats != 8'd0) begin
          r_beats <= r_beats - 8'd1;
          r_rlast <= (r_beats == 8'd1);
        end else begin
          r_rlast <= 1'b0;
        end
      end
    end
  end

  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign bvalid     = r_bvalid;
  assign rid        = r_rid;
  assign rdata      = r_rdata;
  assign rresp      = r_rresp;
  assign rlast      = r_rlast;
  assign rvalid     = r_rvalid;
  assign sram_req   = r_sram_req;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_be    = r_sram_be;
  assign sram_wdata = r_sram_wdata;
  assign dbg_state  = r_state;

endmodule
